// File: rtl/dbg_pkg.sv
// Shared definitions for the debug toggle-handshake bridges: FSM states,
// AXI burst encodings and the burst address stepping helper.
package dbg_pkg;

  localparam int IGNORE_W_DEF = 4;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    W_DATA,
    WAIT_ACK,
    R_RESP,
    B_RESP
  } tog_slv_st_e;

  // Next beat address; size is already clamped to at most 4 bytes.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [1:0]  size,
                                            input logic [7:0]  len,
                                            input logic [1:0]  burst);
    logic [31:0] step;
    logic [31:0] mask;
    step = 32'd1 << size;
    mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
    case (burst)
      BURST_INCR: next_addr = addr + step;
      BURST_WRAP: next_addr = (addr & ~mask) | ((addr + step) & mask);
      default:    next_addr = addr;
    endcase
  endfunction

endpackage

// File: rtl/axi_intf.sv
// 32-bit AXI bundle with 8-bit IDs (AW/W/B/AR/R only).
interface axi_intf;
  logic [7:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [7:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [7:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [7:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/tog_sync.sv
// Toggle synchroniser: 2 sync flops plus an edge-detect flop, with a
// post-reset window during which edges are suppressed.
module tog_sync #(
  parameter int IGNORE_W = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic tog,
  output logic tog_edge,
  output logic ignore
);

  localparam logic [IGNORE_W-1:0] ONE = {{(IGNORE_W-1){1'b0}}, 1'b1};

  logic [2:0]          sync;
  logic [IGNORE_W-1:0] ign_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync    <= '0;
      ign_cnt <= '1;
    end else begin
      sync <= {sync[1:0], tog};
      if (ign_cnt != '0) ign_cnt <= ign_cnt - ONE;
    end
  end

  assign ignore   = ign_cnt[IGNORE_W-1];
  assign tog_edge = (sync[1] ^ sync[2]) & ~ignore;

endmodule

// File: rtl/axi_tog_slv.sv
// AXI slave that issues one toggle-handshake request per data beat to a
// single-outstanding remote peer and returns its answers as R/B responses.
module axi_tog_slv import dbg_pkg::*; #(
  parameter int IGNORE_W = IGNORE_W_DEF
) (
  input  logic        rx_clk,
  input  logic        rx_rstn,
  axi_intf.slave      s_axi_intf,
  output logic        req_tog,
  output logic [31:0] req_addr,
  output logic        req_write,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_wstrb,
  output logic [2:0]  req_prot,
  input  logic        ack_tog,
  input  logic [31:0] ack_rdata,
  input  logic        ack_slverr
);

  tog_slv_st_e st, st_nxt;

  logic [7:0]  id, len, cnt;
  logic [1:0]  sz, burst;
  logic [31:0] addr, addr_nxt;
  logic        wr, err;
  logic        ack_edge, ignore;
  logic        aw_hs, ar_hs, w_hs, r_hs, b_hs, last, ack_hit;
  logic        rvalid_q, bvalid_q, rlast_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q, bresp_q;
  logic        unused;

  tog_sync #(.IGNORE_W(IGNORE_W)) u_ack_sync (
    .clk      (rx_clk),
    .rstn     (rx_rstn),
    .tog      (ack_tog),
    .tog_edge (ack_edge),
    .ignore   (ignore)
  );

  // Write address wins over read when both arrive together.
  assign s_axi_intf.awready = (st == IDLE) && !ignore;
  assign s_axi_intf.arready = (st == IDLE) && !ignore && !s_axi_intf.awvalid;
  assign s_axi_intf.wready  = (st == W_DATA);

  assign s_axi_intf.rvalid = rvalid_q;
  assign s_axi_intf.rid    = id;
  assign s_axi_intf.rdata  = rdata_q;
  assign s_axi_intf.rresp  = rresp_q;
  assign s_axi_intf.rlast  = rlast_q;
  assign s_axi_intf.bvalid = bvalid_q;
  assign s_axi_intf.bid    = id;
  assign s_axi_intf.bresp  = bresp_q;

  // Burst length comes from len alone.
  assign unused = s_axi_intf.wlast;

  assign aw_hs    = s_axi_intf.awvalid && s_axi_intf.awready;
  assign ar_hs    = s_axi_intf.arvalid && s_axi_intf.arready;
  assign w_hs     = s_axi_intf.wvalid  && s_axi_intf.wready;
  assign r_hs     = rvalid_q && s_axi_intf.rready;
  assign b_hs     = bvalid_q && s_axi_intf.bready;
  assign last     = (cnt == len);
  assign ack_hit  = (st == WAIT_ACK) && ack_edge;
  assign addr_nxt = next_addr(addr, sz, len, burst);

  always_ff @(posedge rx_clk or negedge rx_rstn) begin
    if (!rx_rstn) st <= IDLE;
    else          st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:     if (aw_hs) st_nxt = W_DATA;
                else if (ar_hs) st_nxt = WAIT_ACK;
      W_DATA:   if (w_hs) st_nxt = WAIT_ACK;
      WAIT_ACK: if (ack_edge) st_nxt = !wr ? R_RESP : (last ? B_RESP : W_DATA);
      R_RESP:   if (r_hs) st_nxt = last ? IDLE : WAIT_ACK;
      B_RESP:   if (b_hs) st_nxt = IDLE;
      default:  st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rx_clk or negedge rx_rstn) begin
    if (!rx_rstn) begin
      id        <= '0;
      len       <= '0;
      cnt       <= '0;
      sz        <= '0;
      burst     <= '0;
      addr      <= '0;
      wr        <= 1'b0;
      err       <= 1'b0;
      req_tog   <= 1'b0;
      req_addr  <= '0;
      req_write <= 1'b0;
      req_wdata <= '0;
      req_wstrb <= '0;
      req_prot  <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
    end else begin
      if (aw_hs) begin
        id       <= s_axi_intf.awid;
        addr     <= s_axi_intf.awaddr;
        len      <= s_axi_intf.awlen;
        sz       <= s_axi_intf.awsize[2] ? 2'd2 : s_axi_intf.awsize[1:0];
        burst    <= s_axi_intf.awburst;
        req_prot <= s_axi_intf.awprot;
        wr       <= 1'b1;
        cnt      <= '0;
        err      <= 1'b0;
      end
      if (ar_hs) begin
        id        <= s_axi_intf.arid;
        addr      <= s_axi_intf.araddr;
        len       <= s_axi_intf.arlen;
        sz        <= s_axi_intf.arsize[2] ? 2'd2 : s_axi_intf.arsize[1:0];
        burst     <= s_axi_intf.arburst;
        req_prot  <= s_axi_intf.arprot;
        wr        <= 1'b0;
        cnt       <= '0;
        req_addr  <= s_axi_intf.araddr;
        req_write <= 1'b0;
        req_tog   <= ~req_tog;
      end
      if (w_hs) begin
        req_addr  <= addr;
        req_wdata <= s_axi_intf.wdata;
        req_wstrb <= s_axi_intf.wstrb;
        req_write <= 1'b1;
        req_tog   <= ~req_tog;
      end
      if (ack_hit) begin
        if (wr) begin
          err <= err | ack_slverr;
          if (last) begin
            bvalid_q <= 1'b1;
            bresp_q  <= {err | ack_slverr, 1'b0};
          end else begin
            cnt  <= cnt + 8'd1;
            addr <= addr_nxt;
          end
        end else begin
          rvalid_q <= 1'b1;
          rdata_q  <= ack_rdata;
          rresp_q  <= {ack_slverr, 1'b0};
          rlast_q  <= last;
        end
      end
      // Next read beat is requested on the same edge the current one retires.
      if (r_hs) begin
        rvalid_q <= 1'b0;
        if (!last) begin
          cnt      <= cnt + 8'd1;
          addr     <= addr_nxt;
          req_addr <= addr_nxt;
          req_tog  <= ~req_tog;
        end
      end
      if (b_hs) bvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_tog_slv.sv
// Directed bench for axi_tog_slv with a toggle-handshake remote model and
// a response scoreboard.
module tb_axi_tog_slv;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_tog, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic [2:0]  req_prot;
  logic        ack_tog = 1'b0;
  logic [31:0] ack_rdata = '0;
  logic        ack_slverr = 1'b0;

  axi_intf axi();

  axi_tog_slv #(.IGNORE_W(4)) dut (
    .rx_clk     (clk),
    .rx_rstn    (rstn),
    .s_axi_intf (axi),
    .req_tog    (req_tog),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .req_prot   (req_prot),
    .ack_tog    (ack_tog),
    .ack_rdata  (ack_rdata),
    .ack_slverr (ack_slverr)
  );

  initial forever #5 clk = ~clk;

  typedef struct {logic [31:0] addr; logic write; logic [31:0] wdata; logic [3:0] wstrb;} req_t;
  typedef struct {logic [31:0] data; logic err;} ack_t;
  typedef struct {logic isb; logic [7:0] id; logic [31:0] data; logic [1:0] resp; logic last;} rsp_t;

  req_t req_q[$];
  ack_t ack_q[$];
  rsp_t sb[$];

  int total = 0;
  int bad = 0;
  int nflip = 0;
  bit hold = 1'b0;
  logic seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Remote peer: checks each new request, then acknowledges it two cycles later.
  initial begin
    req_t e;
    ack_t a;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        seen = 1'b0;
        continue;
      end
      if (req_tog !== seen) begin
        seen = req_tog;
        nflip++;
        if (req_q.size() == 0) chk("req_unexpected", 1, 0);
        else begin
          e = req_q.pop_front();
          chk("req_addr", req_addr, e.addr);
          chk("req_write", {31'd0, req_write}, {31'd0, e.write});
          if (e.write) begin
            chk("req_wdata", req_wdata, e.wdata);
            chk("req_wstrb", {28'd0, req_wstrb}, {28'd0, e.wstrb});
          end
        end
        if (!hold) begin
          if (ack_q.size() != 0) a = ack_q.pop_front();
          else a = '{data: 32'd0, err: 1'b0};
          repeat (2) @(negedge clk);
          ack_rdata  = a.data;
          ack_slverr = a.err;
          ack_tog    = ~ack_tog;
        end
      end
    end
  end

  // Response monitor; rready/bready stay high so each valid cycle is one beat.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rstn && (axi.rvalid || axi.bvalid)) begin
        if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          if (axi.bvalid) begin
            chk("b_kind", 1, {31'd0, e.isb});
            chk("bid", {24'd0, axi.bid}, {24'd0, e.id});
            chk("bresp", {30'd0, axi.bresp}, {30'd0, e.resp});
          end else begin
            chk("r_kind", 0, {31'd0, e.isb});
            chk("rid", {24'd0, axi.rid}, {24'd0, e.id});
            chk("rdata", axi.rdata, e.data);
            chk("rresp", {30'd0, axi.rresp}, {30'd0, e.resp});
            chk("rlast", {31'd0, axi.rlast}, {31'd0, e.last});
          end
        end
      end
    end
  end

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_req_tog"}, {31'd0, req_tog}, 0);
    chk({tag, "_req_addr"}, req_addr, 0);
    chk({tag, "_req_write"}, {31'd0, req_write}, 0);
    chk({tag, "_req_wdata"}, req_wdata, 0);
    chk({tag, "_req_wstrb_prot"}, {25'd0, req_wstrb, req_prot}, 0);
    chk({tag, "_readies"}, {29'd0, axi.awready, axi.arready, axi.wready}, 0);
    chk({tag, "_valids"}, {30'd0, axi.rvalid, axi.bvalid}, 0);
    chk({tag, "_rdata"}, axi.rdata, 0);
    chk({tag, "_resp_last"}, {27'd0, axi.rresp, axi.bresp, axi.rlast}, 0);
  endtask

  task automatic send_ar(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    logic p;
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arsize = size;
    axi.arburst = burst; axi.arprot = 3'd2; axi.arvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (axi.arready) begin ok = 1'b1; break; end
    end
    p = req_tog;
    @(posedge clk); #1;
    axi.arvalid = 1'b0;
    chk("ar_handshake", {31'd0, ok}, 1);
    if (ok) chk("ar_tog_same_edge", {31'd0, req_tog}, {31'd0, ~p});
  endtask

  task automatic send_aw(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awsize = size;
    axi.awburst = burst; axi.awprot = 3'd1; axi.awvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (axi.awready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    axi.awvalid = 1'b0;
    chk("aw_handshake", {31'd0, ok}, 1);
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    axi.wdata = data; axi.wstrb = strb; axi.wvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (axi.wready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    axi.wvalid = 1'b0;
    chk("w_handshake", {31'd0, ok}, 1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && (sb.size() != 0 || req_q.size() != 0); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk(tag, sb.size() + req_q.size(), 0);
  endtask

  initial begin
    int f0;
    bit rv_seen;
    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
    axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
    axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0;
    axi.arprot = '0; axi.arvalid = 1'b0;
    axi.bready = 1'b1; axi.rready = 1'b1;

    // Reset state and ignore window; stray ack 3 cycles after reset
    repeat (3) @(negedge clk);
    chk_zero_outs("rst");
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1 ack_tog = ~ack_tog;
    @(negedge clk);
    chk("ign_arready_early", {31'd0, axi.arready}, 0);
    repeat (4) @(negedge clk);
    chk("ign_awready_late", {31'd0, axi.awready}, 0);
    repeat (6) @(negedge clk);
    chk("idle_readies", {30'd0, axi.awready, axi.arready}, 3);
    chk("early_ack_no_effect", {29'd0, req_tog, axi.rvalid, axi.bvalid}, 0);

    // Spurious ack while idle
    #1 ack_tog = ~ack_tog;
    repeat (6) @(negedge clk);
    chk("spur_ack_idle", {29'd0, req_tog, axi.rvalid, axi.bvalid}, 0);
    chk("spur_ack_ready", {31'd0, axi.arready}, 1);

    // Single read
    f0 = nflip;
    req_q.push_back('{addr: 32'h1000_0004, write: 1'b0, wdata: 32'd0, wstrb: 4'd0});
    ack_q.push_back('{data: 32'hDEAD_BEEF, err: 1'b0});
    sb.push_back('{isb: 1'b0, id: 8'h05, data: 32'hDEAD_BEEF, resp: 2'b00, last: 1'b1});
    send_ar(8'h05, 32'h1000_0004, 8'd0, 3'd2, 2'b01);
    drain("rd1_drain");
    chk("rd1_flips", nflip - f0, 1);

    // INCR write, error on third beat
    f0 = nflip;
    for (int i = 0; i < 4; i++) begin
      req_q.push_back('{addr: 32'h2000_0000 + 32'(4 * i), write: 1'b1,
                        wdata: 32'hA5A5_0000 + 32'(i), wstrb: 4'hF ^ 4'(i)});
      ack_q.push_back('{data: 32'd0, err: (i == 2)});
    end
    sb.push_back('{isb: 1'b1, id: 8'h21, data: 32'd0, resp: 2'b10, last: 1'b0});
    send_aw(8'h21, 32'h2000_0000, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) send_w(32'hA5A5_0000 + 32'(i), 4'hF ^ 4'(i));
    drain("wr_incr_drain");
    chk("wr_incr_flips", nflip - f0, 4);
    chk("wr_prot", {29'd0, req_prot}, 1);

    // WRAP read wrapping on a 16-byte boundary
    f0 = nflip;
    for (int i = 0; i < 4; i++) begin
      req_q.push_back('{addr: 32'h3000_0030 | ((32'h38 + 32'(4 * i)) & 32'hF), write: 1'b0,
                        wdata: 32'd0, wstrb: 4'd0});
      ack_q.push_back('{data: 32'h0BAD_0000 + 32'(i), err: 1'b0});
      sb.push_back('{isb: 1'b0, id: 8'h33, data: 32'h0BAD_0000 + 32'(i), resp: 2'b00, last: (i == 3)});
    end
    send_ar(8'h33, 32'h3000_0038, 8'd3, 3'd2, 2'b10);
    drain("rd_wrap_drain");
    chk("rd_wrap_flips", nflip - f0, 4);

    // Simultaneous AW and AR: write first, read after B
    req_q.push_back('{addr: 32'h4000_0000, write: 1'b1, wdata: 32'h1234_5678, wstrb: 4'hC});
    req_q.push_back('{addr: 32'h5000_0000, write: 1'b0, wdata: 32'd0, wstrb: 4'd0});
    ack_q.push_back('{data: 32'd0, err: 1'b0});
    ack_q.push_back('{data: 32'h5555_AAAA, err: 1'b1});
    sb.push_back('{isb: 1'b1, id: 8'h41, data: 32'd0, resp: 2'b00, last: 1'b0});
    sb.push_back('{isb: 1'b0, id: 8'h42, data: 32'h5555_AAAA, resp: 2'b10, last: 1'b1});
    @(posedge clk); #1;
    axi.awid = 8'h41; axi.awaddr = 32'h4000_0000; axi.awlen = 8'd0; axi.awsize = 3'd2;
    axi.awburst = 2'b01; axi.awvalid = 1'b1;
    axi.arid = 8'h42; axi.araddr = 32'h5000_0000; axi.arlen = 8'd0; axi.arsize = 3'd2;
    axi.arburst = 2'b01; axi.arvalid = 1'b1;
    @(negedge clk);
    chk("sim_readies", {30'd0, axi.awready, axi.arready}, 2);
    @(posedge clk); #1;
    axi.awvalid = 1'b0;
    send_w(32'h1234_5678, 4'hC);
    begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (axi.arready) begin ok = 1'b1; break; end
      end
      chk("sim_ar_handshake", {31'd0, ok}, 1);
      chk("sim_b_before_ar", sb.size(), 1);
    end
    @(posedge clk); #1;
    axi.arvalid = 1'b0;
    drain("sim_drain");

    // Reset while waiting for the first ack of a 2-beat read
    hold = 1'b1;
    req_q.push_back('{addr: 32'h6000_0000, write: 1'b0, wdata: 32'd0, wstrb: 4'd0});
    send_ar(8'h50, 32'h6000_0000, 8'd1, 3'd2, 2'b01);
    repeat (4) @(negedge clk);
    chk("pre_rst_pending", {31'd0, req_tog}, {31'd0, seen});
    @(posedge clk); #1;
    rstn = 1'b0;
    @(negedge clk);
    chk_zero_outs("midrst");
    @(posedge clk); #1;
    ack_q.delete();
    req_q.delete();
    hold = 1'b0;
    rstn = 1'b1;
    rv_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (axi.rvalid) rv_seen = 1'b1;
    end
    chk("midrst_no_rvalid", {31'd0, rv_seen}, 0);
    req_q.push_back('{addr: 32'h7000_0010, write: 1'b0, wdata: 32'd0, wstrb: 4'd0});
    ack_q.push_back('{data: 32'hCAFE_F00D, err: 1'b0});
    sb.push_back('{isb: 1'b0, id: 8'h51, data: 32'hCAFE_F00D, resp: 2'b00, last: 1'b1});
    send_ar(8'h51, 32'h7000_0010, 8'd0, 3'd2, 2'b01);
    drain("post_rst_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
